// File: rtl/iq_demixer.sv
//----------------------------------------------------------------------------
// Module      : iq_demixer
// Description : Receive-side IQ demixer. Multiplies a real 15-bit sample
//               stream by ternary I/Q LO codes, integrates-and-dumps over
//               DECIM accepted samples and presents one decimated signed
//               I/Q pair per window through a valid/ready output register.
// Options     : define DEMIX_SAT_EN to saturate the narrowed result to
//               [-16384, +16383]; otherwise the result wraps to 15 bits.
// Ports       : clock, reset      - rising-edge clock, sync active-high reset
//               in_valid          - demix_in / LO_i / LO_q valid this cycle
//               demix_in [14:0]   - signed real input sample
//               LO_i, LO_q [1:0]  - LO codes: [1] -> -x, else [0] -> +x, else 0
//               sync_clr          - restart integration window
//               out_i, out_q      - signed decimated I/Q result
//               out_valid         - result held in the output register
//               out_ready         - consumer accepts when valid && ready
//               overrun           - sticky: a window result was dropped
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module iq_demixer #(
  parameter int DECIM      = 8,
  parameter int LOG2_DECIM = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [14:0] demix_in,
  input  logic        [1:0]  LO_i,
  input  logic        [1:0]  LO_q,
  input  logic               sync_clr,
  output logic signed [14:0] out_i,
  output logic signed [14:0] out_q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overrun
);

  // Wide enough that DECIM products of magnitude up to 16384 never wrap.
  localparam int c_ACC_W = 16 + LOG2_DECIM;
  localparam logic [LOG2_DECIM-1:0] c_CNT_LAST = LOG2_DECIM'(DECIM - 1);

  // Ternary LO multiply. The sample is widened before negation so that
  // -(-16384) is representable.
  function automatic logic signed [15:0] lo_mix(input logic [1:0]         code,
                                                input logic signed [15:0] x);
    if (code[1])      return -x;
    else if (code[0]) return x;
    else              return 16'sd0;
  endfunction

`ifdef DEMIX_SAT_EN
  localparam logic signed [c_ACC_W-1:0] c_SAT_MAX = c_ACC_W'(16383);
  localparam logic signed [c_ACC_W-1:0] c_SAT_MIN = -c_ACC_W'(16384);

  function automatic logic signed [14:0] narrow(input logic signed [c_ACC_W-1:0] v);
    if (v > c_SAT_MAX)      return 15'sh3FFF;
    else if (v < c_SAT_MIN) return 15'sh4000;
    else                    return 15'(v);
  endfunction
`else
  // Two's-complement wrap: +16384 becomes -16384.
  function automatic logic signed [14:0] narrow(input logic signed [c_ACC_W-1:0] v);
    return 15'(v);
  endfunction
`endif

  logic signed [15:0]         w_x16;
  logic signed [c_ACC_W-1:0]  w_prod_i;
  logic signed [c_ACC_W-1:0]  w_prod_q;
  logic signed [c_ACC_W-1:0]  w_sum_i;
  logic signed [c_ACC_W-1:0]  w_sum_q;
  logic signed [c_ACC_W-1:0]  w_shift_i;
  logic signed [c_ACC_W-1:0]  w_shift_q;
  logic signed [14:0]         w_res_i;
  logic signed [14:0]         w_res_q;
  logic                       w_dump;

  logic signed [c_ACC_W-1:0]  r_acc_i;
  logic signed [c_ACC_W-1:0]  r_acc_q;
  logic [LOG2_DECIM-1:0]      r_cnt;
  logic signed [14:0]         r_out_i;
  logic signed [14:0]         r_out_q;
  logic                       r_out_valid;
  logic                       r_overrun;

  assign w_x16     = {demix_in[14], demix_in};
  assign w_prod_i  = c_ACC_W'(lo_mix(LO_i, w_x16));
  assign w_prod_q  = c_ACC_W'(lo_mix(LO_q, w_x16));
  assign w_sum_i   = r_acc_i + w_prod_i;
  assign w_sum_q   = r_acc_q + w_prod_q;
  assign w_shift_i = w_sum_i >>> LOG2_DECIM;
  assign w_shift_q = w_sum_q >>> LOG2_DECIM;
  assign w_res_i   = narrow(w_shift_i);
  assign w_res_q   = narrow(w_shift_q);

  // A window closes on its DECIM-th accepted sample unless sync_clr
  // discards that sample and restarts the window instead.
  assign w_dump = in_valid && !sync_clr && (r_cnt == c_CNT_LAST);

  // Integrate-and-dump accumulators and window counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_cnt   <= '0;
    end else if (sync_clr || w_dump) begin
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_cnt   <= '0;
    end else if (in_valid) begin
      r_acc_i <= w_sum_i;
      r_acc_q <= w_sum_q;
      r_cnt   <= r_cnt + LOG2_DECIM'(1);
    end
  end

  // Output register. A dump replaces a result being accepted in the same
  // cycle; a dump into an unaccepted result is dropped and flagged.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_i     <= '0;
      r_out_q     <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_dump) begin
      if (!r_out_valid || out_ready) begin
        r_out_i     <= w_res_i;
        r_out_q     <= w_res_q;
        r_out_valid <= 1'b1;
      end else begin
        r_overrun   <= 1'b1;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_i     = r_out_i;
  assign out_q     = r_out_q;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_iq_demixer.sv
//----------------------------------------------------------------------------
// Module      : tb_iq_demixer
// Description : Self-checking bench for iq_demixer (DECIM=8). A driver
//               issues stimulus and predicts results from a window-of-
//               samples reference model into a queue; a monitor on the
//               falling edge compares DUT outputs against that queue.
//               Honours DEMIX_SAT_EN the same way as the design.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_iq_demixer;

  localparam int DECIM      = 8;
  localparam int LOG2_DECIM = 3;

  logic               clock     = 1'b0;
  logic               reset     = 1'b1;
  logic               in_valid  = 1'b0;
  logic signed [14:0] demix_in  = '0;
  logic        [1:0]  LO_i      = '0;
  logic        [1:0]  LO_q      = '0;
  logic               sync_clr  = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [14:0] out_i;
  logic signed [14:0] out_q;
  logic               out_valid;
  logic               overrun;

  always #5 clock = ~clock;

  iq_demixer #(
    .DECIM      (DECIM),
    .LOG2_DECIM (LOG2_DECIM)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .demix_in  (demix_in),
    .LO_i      (LO_i),
    .LO_q      (LO_q),
    .sync_clr  (sync_clr),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  typedef struct {
    int i;
    int q;
  } pair_t;

  pair_t exp_q[$];     // predicted results, in delivery order
  int    win_i[$];     // products of the current window
  int    win_q[$];
  bit    m_held = 1'b0; // model: a result is waiting in the output register
  bit    m_ovr  = 1'b0; // model: sticky overrun
  bit    mon_en = 1'b0;
  int    n_pass  = 0;
  int    n_total = 0;

  function automatic int lo_mul(input logic [1:0] code, input int x);
    if (code[1]) return -x;
    if (code[0]) return x;
    return 0;
  endfunction

  function automatic int narrow(input int v);
`ifdef DEMIX_SAT_EN
    if (v > 16383)  return 16383;
    if (v < -16384) return -16384;
    return v;
`else
    return ((v + 16384) & 32'h7FFF) - 16384;
`endif
  endfunction

  // Floor of sum/DECIM, as an arithmetic right shift would give.
  function automatic int window_result(input int s[$]);
    int total = 0;
    int q;
    foreach (s[k]) total += s[k];
    q = total / DECIM;
    if ((total % DECIM != 0) && (total < 0)) q = q - 1;
    return narrow(q);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // One clock of stimulus, followed by the model's view of that edge.
  task automatic cycle(input bit rst, input bit iv, input int din,
                       input logic [1:0] li, input logic [1:0] lq,
                       input bit sc, input bit rdy);
    bit    dump;
    pair_t r;
    reset     = rst;
    in_valid  = iv;
    demix_in  = 15'(din);
    LO_i      = li;
    LO_q      = lq;
    sync_clr  = sc;
    out_ready = rdy;
    @(posedge clock);
    dump = 1'b0;
    r.i  = 0;
    r.q  = 0;
    if (rst) begin
      win_i.delete();
      win_q.delete();
      exp_q.delete();
      m_held = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      if (sc) begin
        win_i.delete();
        win_q.delete();
      end else if (iv) begin
        win_i.push_back(lo_mul(li, din));
        win_q.push_back(lo_mul(lq, din));
        if (win_i.size() == DECIM) begin
          dump = 1'b1;
          r.i  = window_result(win_i);
          r.q  = window_result(win_q);
          win_i.delete();
          win_q.delete();
        end
      end
      if (dump) begin
        if (m_held && !rdy) m_ovr = 1'b1;
        else begin
          exp_q.push_back(r);
          m_held = 1'b1;
        end
      end else if (m_held && rdy) begin
        m_held = 1'b0;
      end
    end
    #1;
  endtask

  task automatic samples(input int n, input int din, input logic [1:0] li,
                         input logic [1:0] lq, input bit rdy);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b1, din, li, lq, 1'b0, rdy);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 0, 2'b00, 2'b00, 1'b0, 1'b1);
  endtask

  // Monitor: compares the presented result with the head of the queue and
  // retires it when the consumer accepts.
  always @(negedge clock) begin
    if (mon_en) begin
      check("out_valid", int'(out_valid), int'(m_held));
      check("overrun", int'(overrun), int'(m_ovr));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL result: out_valid with no result expected (t=%0t)", $time);
        end else begin
          check("out_i", int'(out_i), exp_q[0].i);
          check("out_q", int'(out_q), exp_q[0].q);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 0, 2'b00, 2'b00, 1'b0, 1'b0);
    check("reset out_i", int'(out_i), 0);
    check("reset out_q", int'(out_q), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset overrun", int'(overrun), 0);
    mon_en = 1'b1;

    // Basic I-only window, then negated I / positive Q, then cancelling I.
    samples(8, 1000, 2'b01, 2'b00, 1'b1);
    idle(3);
    samples(8, 1000, 2'b10, 2'b01, 1'b1);
    idle(3);
    for (int k = 0; k < 8; k++)
      cycle(1'b0, 1'b1, 1000, (k % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 1'b0, 1'b1);
    idle(3);

    // Most negative input, negated: +16384 after decimation.
    samples(8, -16384, 2'b10, 2'b11, 1'b1);
    idle(3);

    // Gapped input: 8 samples spread over 16 cycles.
    for (int k = 0; k < 16; k++)
      cycle(1'b0, (k % 2 == 0), 1234, 2'b01, 2'b10, 1'b0, 1'b1);
    idle(3);

    // Reset and sync_clr mid-window discard the partial sums.
    samples(5, 1000, 2'b01, 2'b01, 1'b1);
    cycle(1'b1, 1'b0, 0, 2'b00, 2'b00, 1'b0, 1'b1);
    samples(8, 200, 2'b01, 2'b01, 1'b1);
    idle(3);
    samples(5, 1000, 2'b01, 2'b01, 1'b1);
    cycle(1'b0, 1'b1, 1000, 2'b01, 2'b01, 1'b1, 1'b1);
    samples(8, 200, 2'b01, 2'b01, 1'b1);
    idle(3);

    // Back-pressure across two windows: first result held, second dropped.
    samples(16, 777, 2'b01, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 0, 2'b00, 2'b00, 1'b0, 1'b0);
    idle(3);

    // Randomised traffic including boundary samples and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      int din;
      case ($urandom_range(0, 7))
        0:       din = -16384;
        1:       din = 16383;
        default: din = int'($urandom_range(0, 32767)) - 16384;
      endcase
      cycle($urandom_range(0, 399) == 0,
            $urandom_range(0, 3) != 0,
            din,
            2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)),
            $urandom_range(0, 49) == 0,
            $urandom_range(0, 3) != 0);
    end

    idle(10);
    check("drained", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
